// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified instruction/data memory port: the
// transaction FSM states and the owner encoding. A later cache controller on
// the same port is expected to reuse these.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates the instruction-fetch (IF) port and the data (MEM) port onto one
// shared, single-ported, variable-latency memory. MEM has priority; IF is
// guaranteed a grant after STARVE_MAX consecutive MEM grants while it waits.
// Each transaction runs IDLE -> BUSY -> DONE, so a held request is never
// re-granted in the cycle its ready pulses.
//
// Ports
//   clk_i, rst_i                clock (rising edge), async active-low reset
//   if_req_i/if_addr_i          fetch request + address (held until ready)
//   if_data_o/if_ready_o        registered fetch data + one-cycle ready pulse
//   mem_req_i/mem_we_i/
//   mem_addr_i/mem_wdata_i      data request fields (held until ready)
//   mem_rdata_o/mem_ready_o     registered read data + one-cycle ready pulse
//   stall_o                     combinational pipeline stall
//   ext_req_o/ext_we_o/
//   ext_addr_o/ext_wdata_o      registered shared-memory request
//   ext_ack_i/ext_rdata_i       shared-memory completion + read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ready_o,
  output logic              stall_o,
  output logic              ext_req_o,
  output logic              ext_we_o,
  output logic [ADDR_W-1:0] ext_addr_o,
  output logic [DATA_W-1:0] ext_wdata_o,
  input  logic              ext_ack_i,
  input  logic [DATA_W-1:0] ext_rdata_i
);

  localparam int unsigned          CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_owner;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic              w_grant;
  logic              w_grant_owner;
  logic              w_complete;

  logic              r_ext_req;
  logic              r_ext_we;
  logic [ADDR_W-1:0] r_ext_addr;
  logic [DATA_W-1:0] r_ext_wdata;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_ready;
  logic              r_mem_ready;

  // Next-state, grant selection and starvation counter update.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant       = 1'b0;
    w_grant_owner = OWN_IF;
    w_starve_nxt  = r_starve_cnt;
    w_complete    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (mem_req_i && if_req_i) begin
          w_grant       = 1'b1;
          w_grant_owner = (r_starve_cnt == CNT_MAX) ? OWN_IF : OWN_MEM;
        end else if (mem_req_i) begin
          w_grant       = 1'b1;
          w_grant_owner = OWN_MEM;
        end else if (if_req_i) begin
          w_grant       = 1'b1;
          w_grant_owner = OWN_IF;
        end
        if (w_grant) begin
          w_state_nxt = ST_BUSY;
        end
        // Counter only grows while IF is waiting; an IF grant or an idle
        // IF port restarts the count.
        if (!if_req_i) begin
          w_starve_nxt = '0;
        end else if (w_grant && (w_grant_owner == OWN_IF)) begin
          w_starve_nxt = '0;
        end else if (w_grant && (r_starve_cnt != CNT_MAX)) begin
          w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (ext_ack_i) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_IF;
      r_starve_cnt <= '0;
      r_ext_req    <= 1'b0;
      r_ext_we     <= 1'b0;
      r_ext_addr   <= '0;
      r_ext_wdata  <= '0;
      r_if_data    <= '0;
      r_mem_rdata  <= '0;
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      // Ready is set on the acknowledged BUSY cycle so that it is visible
      // exactly in DONE, without a combinational path from ext_ack_i.
      r_if_ready   <= 1'b0;
      r_mem_ready  <= 1'b0;
      if (w_grant) begin
        r_owner     <= w_grant_owner;
        r_ext_req   <= 1'b1;
        r_ext_addr  <= (w_grant_owner == OWN_MEM) ? mem_addr_i : if_addr_i;
        r_ext_we    <= (w_grant_owner == OWN_MEM) && mem_we_i;
        r_ext_wdata <= (w_grant_owner == OWN_MEM) ? mem_wdata_i : '0;
      end
      if (w_complete) begin
        r_ext_req <= 1'b0;
        if (r_owner == OWN_IF) begin
          r_if_ready <= 1'b1;
          r_if_data  <= ext_rdata_i;
        end else begin
          r_mem_ready <= 1'b1;
          if (!r_ext_we) begin
            r_mem_rdata <= ext_rdata_i;
          end
        end
      end
    end
  end

  assign if_data_o   = r_if_data;
  assign if_ready_o  = r_if_ready;
  assign mem_rdata_o = r_mem_rdata;
  assign mem_ready_o = r_mem_ready;
  assign ext_req_o   = r_ext_req;
  assign ext_we_o    = r_ext_we;
  assign ext_addr_o  = r_ext_addr;
  assign ext_wdata_o = r_ext_wdata;
  assign stall_o     = (if_req_i & ~r_if_ready) | (mem_req_i & ~r_mem_ready);

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed scenarios (latency, waits, priority order, reset, spurious ack)
// followed by randomized traffic checked against a transaction-level model:
// a word array for the shared memory, a starvation count of MEM grants since
// IF was last served, and per-requester expected read data.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_data_o;
  logic          if_ready_o;
  logic          mem_req_i;
  logic          mem_we_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [DW-1:0] mem_rdata_o;
  logic          mem_ready_o;
  logic          stall_o;
  logic          ext_req_o;
  logic          ext_we_o;
  logic [AW-1:0] ext_addr_o;
  logic [DW-1:0] ext_wdata_o;
  logic          ext_ack_i;
  logic [DW-1:0] ext_rdata_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_data_o  (if_data_o),
    .if_ready_o (if_ready_o),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_addr_i (mem_addr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .mem_ready_o(mem_ready_o),
    .stall_o    (stall_o),
    .ext_req_o  (ext_req_o),
    .ext_we_o   (ext_we_o),
    .ext_addr_o (ext_addr_o),
    .ext_wdata_o(ext_wdata_o),
    .ext_ack_i  (ext_ack_i),
    .ext_rdata_i(ext_rdata_i)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic clear_inputs();
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    ext_ack_i   = 1'b0;
    ext_rdata_i = '0;
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  // One request on one port against a memory with `waits` wait cycles; the
  // memory keeps ext_ack_i high for `linger` cycles after completion.
  task automatic single_txn(input logic is_if, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdat,
                            input int waits, input int linger);
    int ext_cycles;
    int ready_cnt;
    int ready_cyc;
    int ack_left;
    logic rdy;
    logic other;
    logic [31:0] old_mrd;
    logic [31:0] old_ifd;
    old_mrd = mem_rdata_o;
    old_ifd = if_data_o;
    @(negedge clk_i);
    if (is_if) begin
      if_req_i  = 1'b1;
      if_addr_i = addr;
    end else begin
      mem_req_i   = 1'b1;
      mem_we_i    = we;
      mem_addr_i  = addr;
      mem_wdata_i = wdata;
    end
    #1 check("stall_cycle0", stall_o, 1);
    ext_cycles = 0;
    ready_cnt  = 0;
    ready_cyc  = -1;
    ack_left   = linger;
    for (int cyc = 1; cyc <= waits + 6; cyc++) begin
      @(negedge clk_i);
      ext_ack_i = 1'b0;
      rdy   = is_if ? if_ready_o : mem_ready_o;
      other = is_if ? mem_ready_o : if_ready_o;
      check("other_ready", other, 0);
      if (rdy) begin
        ready_cnt++;
        if (ready_cyc < 0) ready_cyc = cyc;
        check("stall_at_ready", stall_o, 0);
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
      end else if (ready_cyc < 0) begin
        check("stall_waiting", stall_o, 1);
      end
      if (ext_req_o) begin
        ext_cycles++;
        check("ext_we", ext_we_o, is_if ? 1'b0 : we);
        check("ext_addr", ext_addr_o, addr);
        if (!is_if && we) check("ext_wdata", ext_wdata_o, wdata);
        if (ext_cycles == waits + 1) begin
          ext_ack_i   = 1'b1;
          ext_rdata_i = rdat;
        end
      end else if (ready_cyc > 0 && ack_left > 0) begin
        ext_ack_i   = 1'b1;
        ext_rdata_i = ~rdat;
        ack_left--;
      end
    end
    ext_ack_i = 1'b0;
    check("ready_latency", ready_cyc, waits + 2);
    check("ready_pulses", ready_cnt, 1);
    check("ext_req_cycles", ext_cycles, waits + 1);
    if (is_if) begin
      check("if_data", if_data_o, rdat);
      check("mem_rdata_kept", mem_rdata_o, old_mrd);
    end else begin
      check("mem_rdata", mem_rdata_o, we ? old_mrd : rdat);
      check("if_data_kept", if_data_o, old_ifd);
    end
  endtask

  task automatic both_txn();
    int if_cyc;
    int mem_cyc;
    int if_cnt;
    int mem_cnt;
    if_cyc = -1; mem_cyc = -1; if_cnt = 0; mem_cnt = 0;
    @(negedge clk_i);
    if_req_i   = 1'b1;
    if_addr_i  = 32'h0000_0104;
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0000_0208;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk_i);
      ext_ack_i = 1'b0;
      if (if_ready_o) begin
        if_cnt++;
        if (if_cyc < 0) if_cyc = cyc;
        if_req_i = 1'b0;
      end
      if (mem_ready_o) begin
        mem_cnt++;
        if (mem_cyc < 0) mem_cyc = cyc;
        mem_req_i = 1'b0;
      end
      if (ext_req_o) begin
        ext_ack_i   = 1'b1;
        ext_rdata_i = word_of(ext_addr_o);
      end
    end
    ext_ack_i = 1'b0;
    check("both_mem_cycle", mem_cyc, 2);
    check("both_if_cycle", if_cyc, 5);
    check("both_mem_pulses", mem_cnt, 1);
    check("both_if_pulses", if_cnt, 1);
    check("both_if_data", if_data_o, word_of(32'h0000_0104));
    check("both_mem_data", mem_rdata_o, word_of(32'h0000_0208));
  endtask

  // Both ports request without pause; grant order must be MEM x4 then IF.
  task automatic starve_order();
    logic own_seq [10];
    int   n_grants;
    logic prev_req;
    n_grants = 0;
    prev_req = 1'b0;
    @(negedge clk_i);
    if_req_i   = 1'b1;
    if_addr_i  = 32'h0000_0100;
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0000_0200;
    for (int cyc = 0; cyc < 45; cyc++) begin
      @(negedge clk_i);
      ext_ack_i = 1'b0;
      if (ext_req_o && !prev_req && n_grants < 10) begin
        own_seq[n_grants] = (ext_addr_o == 32'h0000_0100) ? OWN_IF : OWN_MEM;
        n_grants++;
      end
      prev_req = ext_req_o;
      if (ext_req_o) begin
        ext_ack_i   = 1'b1;
        ext_rdata_i = word_of(ext_addr_o);
      end
    end
    check("starve_grant_count", n_grants, 10);
    for (int k = 0; k < n_grants; k++) begin
      check($sformatf("starve_grant_%0d", k), own_seq[k], ((k % 5) == 4) ? OWN_IF : OWN_MEM);
    end
    clear_inputs();
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk_i);
      ext_ack_i = ext_req_o;
    end
    ext_ack_i = 1'b0;
  endtask

  task automatic reset_mid_busy();
    @(negedge clk_i);
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0000_0030;
    @(negedge clk_i);
    check("rst_busy_req", ext_req_o, 1);
    @(negedge clk_i);
    check("rst_busy_hold", ext_req_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check("rst_ext_req", ext_req_o, 0);
    check("rst_mem_ready", mem_ready_o, 0);
    check("rst_if_ready", if_ready_o, 0);
    check("rst_stall_follows", stall_o, 1);
    @(negedge clk_i);
    mem_req_i   = 1'b0;
    ext_ack_i   = 1'b1;
    ext_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk_i);
      check("late_ack_req", ext_req_o, 0);
      check("late_ack_mready", mem_ready_o, 0);
      check("late_ack_iready", if_ready_o, 0);
    end
    ext_ack_i = 1'b0;
    check("late_ack_rdata", mem_rdata_o, 0);
    single_txn(1'b0, 1'b0, 32'h0000_0034, 32'h0, 32'h1357_9BDF, 1, 0);
  endtask

  // Randomized traffic against the transaction-level model.
  task automatic random_phase(input int n_cycles);
    logic [31:0] mdl_mem [16];
    int   starve;
    int   wait_left;
    int   if_wait;
    int   mem_wait;
    logic inflight, ack_prev, ack_now, is_done;
    logic prev_if, prev_mem, prev_ext_req, exp_grant, grant_seen;
    logic own_exp, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rd, last_if_rd, last_mem_rd;
    for (int i = 0; i < 16; i++) mdl_mem[i] = $urandom;
    starve = 0; wait_left = 0; if_wait = 0; mem_wait = 0;
    inflight = 0; ack_prev = 0; prev_if = 0; prev_mem = 0;
    prev_ext_req = 0; exp_grant = 0; own_exp = OWN_IF; exp_we = 0;
    exp_addr = '0; exp_wdata = '0; exp_rd = '0;
    last_if_rd = '0; last_mem_rd = '0;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      @(negedge clk_i);
      is_done    = ack_prev;
      grant_seen = ext_req_o && !prev_ext_req;
      check("rnd_grant_time", grant_seen, exp_grant);
      if (grant_seen) begin
        if (prev_if && prev_mem) own_exp = (starve == SMAX) ? OWN_IF : OWN_MEM;
        else                     own_exp = prev_mem ? OWN_MEM : OWN_IF;
        if (own_exp == OWN_IF)       starve = 0;
        else if (prev_if && starve < SMAX) starve++;
        exp_addr  = (own_exp == OWN_IF) ? if_addr_i : mem_addr_i;
        exp_we    = (own_exp == OWN_MEM) && mem_we_i;
        exp_wdata = mem_wdata_i;
        check("rnd_ext_addr", ext_addr_o, exp_addr);
        check("rnd_ext_we", ext_we_o, exp_we);
        if (exp_we) check("rnd_ext_wdata", ext_wdata_o, exp_wdata);
        inflight  = 1'b1;
        wait_left = $urandom_range(0, 3);
      end
      check("rnd_if_ready", if_ready_o, is_done && (own_exp == OWN_IF));
      check("rnd_mem_ready", mem_ready_o, is_done && (own_exp == OWN_MEM));
      if (is_done) begin
        if (own_exp == OWN_IF) last_if_rd = exp_rd;
        else if (!exp_we)      last_mem_rd = exp_rd;
        inflight = 1'b0;
      end
      check("rnd_ext_req", ext_req_o, inflight);
      check("rnd_if_data", if_data_o, last_if_rd);
      check("rnd_mem_rdata", mem_rdata_o, last_mem_rd);
      check("rnd_stall", stall_o, (if_req_i && !if_ready_o) || (mem_req_i && !mem_ready_o));
      // Shared memory responder.
      ack_now = 1'b0;
      if (ext_req_o && inflight) begin
        if (wait_left == 0) ack_now = 1'b1;
        else wait_left--;
      end
      if (ack_now) begin
        exp_rd      = mdl_mem[exp_addr[5:2]];
        ext_rdata_i = exp_rd;
        if (exp_we) mdl_mem[exp_addr[5:2]] = exp_wdata;
      end else begin
        ext_rdata_i = $urandom;
      end
      ext_ack_i = ack_now || (!ext_req_o && ($urandom_range(0, 3) == 0));
      ack_prev  = ack_now;
      // Requesters.
      if (if_req_i && if_ready_o) begin
        if_req_i = ($urandom_range(0, 1) == 1);
        if_addr_i = 32'($urandom_range(0, 15)) << 2;
        if_wait = 0;
      end else if (if_req_i) begin
        if_wait++;
        if (if_wait == 200) check("rnd_if_timeout", 0, 1);
      end else if ($urandom_range(0, 2) == 0) begin
        if_req_i  = 1'b1;
        if_addr_i = 32'($urandom_range(0, 15)) << 2;
      end
      if (mem_req_i && mem_ready_o) begin
        mem_req_i = ($urandom_range(0, 1) == 1);
        mem_we_i    = ($urandom_range(0, 1) == 1);
        mem_addr_i  = 32'($urandom_range(0, 15)) << 2;
        mem_wdata_i = $urandom;
        mem_wait = 0;
      end else if (mem_req_i) begin
        mem_wait++;
        if (mem_wait == 200) check("rnd_mem_timeout", 0, 1);
      end else if ($urandom_range(0, 1) == 0) begin
        mem_req_i   = 1'b1;
        mem_we_i    = ($urandom_range(0, 1) == 1);
        mem_addr_i  = 32'($urandom_range(0, 15)) << 2;
        mem_wdata_i = $urandom;
      end
      exp_grant    = !inflight && !is_done && (if_req_i || mem_req_i);
      prev_if      = if_req_i;
      prev_mem     = mem_req_i;
      prev_ext_req = ext_req_o;
    end
  endtask

  initial begin
    rst_i = 1'b0;
    clear_inputs();
    reset_dut();
    #1;
    check("reset_ext_req", ext_req_o, 0);
    check("reset_ext_we", ext_we_o, 0);
    check("reset_ext_addr", ext_addr_o, 0);
    check("reset_if_ready", if_ready_o, 0);
    check("reset_mem_ready", mem_ready_o, 0);
    check("reset_if_data", if_data_o, 0);
    check("reset_mem_rdata", mem_rdata_o, 0);
    check("reset_stall", stall_o, 0);

    single_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0050_0093, 0, 0);
    single_txn(1'b0, 1'b0, 32'h0000_0014, 32'h0, 32'hCAFE_F00D, 0, 0);
    single_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0BAD_0BAD, 3, 0);
    single_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h1111_2222, 2, 3);
    both_txn();
    starve_order();
    reset_mid_busy();

    reset_dut();
    random_phase(4000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule : tb_mem_port_arbiter
